// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register for the
// 16-bit ThinPad CPU. Replays fetches lost to RAM1 conflicts, freezes during
// multi-cycle UART accesses and applies branch redirects.
//
// Optional feature: define FETCH_STALL_COUNTER_EN to add the StallCount port,
// a saturating count of conflict/freeze cycles.
module fetch_unit #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] NOP_INSTRUCT = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instruct,
    input  logic        MemConflict,
    input  logic        noStop,
    input  logic        HazardStall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic [15:0] pc,
    output logic [15:0] IfIdInstruct,
    output logic [15:0] IfIdPc,
    output logic        IfIdValid,
    output logic [1:0]  FetchState
`ifdef FETCH_STALL_COUNTER_EN
    ,
    output logic [15:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StReplay = 2'd1,
        StFrozen = 2'd2
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  ifid_pc_q, ifid_pc_d;
    logic         valid_q, valid_d;

    // State register for PC, IF/ID and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTRUCT;
            ifid_pc_q <= 16'h0000;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state selection in priority order: freeze, branch, conflict, hazard, fetch
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        if (!noStop) begin
            // UART access in flight: everything holds, branch source must retry
            state_d = StFrozen;
        end else if (BranchTaken) begin
            state_d = StRun;
            pc_d    = BranchTarget;
            instr_d = NOP_INSTRUCT;
            valid_d = 1'b0;
        end else if (MemConflict) begin
            // Instruct is garbage this cycle; keep pc so the same word is refetched
            state_d = StReplay;
            instr_d = NOP_INSTRUCT;
            valid_d = 1'b0;
        end else if (HazardStall) begin
            state_d = StRun;
        end else begin
            state_d   = StRun;
            instr_d   = Instruct;
            ifid_pc_d = pc_q + 16'h0001;
            valid_d   = 1'b1;
            pc_d      = pc_q + 16'h0001;
        end
    end

    assign pc           = pc_q;
    assign IfIdInstruct = instr_q;
    assign IfIdPc       = ifid_pc_q;
    assign IfIdValid    = valid_q;
    assign FetchState   = state_q;

`ifdef FETCH_STALL_COUNTER_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles lost to conflicts or UART freezes
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((MemConflict || !noStop) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps followed by randomized stimulus,
// each cycle compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Instruct = 16'h0000;
    logic        MemConflict = 1'b0;
    logic        noStop = 1'b1;
    logic        HazardStall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchTarget = 16'h0000;
    logic [15:0] pc;
    logic [15:0] IfIdInstruct;
    logic [15:0] IfIdPc;
    logic        IfIdValid;
    logic [1:0]  FetchState;
`ifdef FETCH_STALL_COUNTER_EN
    logic [15:0] StallCount;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    logic [15:0] m_pc, m_instr, m_ipc, m_sc;
    logic        m_valid;
    int          m_state;

    fetch_unit #(
        .RESET_PC    (16'h0000),
        .NOP_INSTRUCT(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Instruct    (Instruct),
        .MemConflict (MemConflict),
        .noStop      (noStop),
        .HazardStall (HazardStall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .pc          (pc),
        .IfIdInstruct(IfIdInstruct),
        .IfIdPc      (IfIdPc),
        .IfIdValid   (IfIdValid),
        .FetchState  (FetchState)
`ifdef FETCH_STALL_COUNTER_EN
        ,
        .StallCount  (StallCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the stage rules to the inputs sampled at this edge
    task automatic model_step();
        if (rst) begin
            m_pc = 16'h0000; m_instr = NOP; m_ipc = 16'h0000;
            m_valid = 1'b0; m_state = 0; m_sc = 16'h0000;
        end else begin
            if ((MemConflict || !noStop) && m_sc != 16'hFFFF) m_sc = m_sc + 1;
            if (!noStop) begin
                m_state = 2;
            end else if (BranchTaken) begin
                m_pc = BranchTarget; m_instr = NOP; m_valid = 1'b0; m_state = 0;
            end else if (MemConflict) begin
                m_instr = NOP; m_valid = 1'b0; m_state = 1;
            end else if (HazardStall) begin
                m_state = 0;
            end else begin
                m_instr = Instruct; m_ipc = m_pc + 1; m_valid = 1'b1;
                m_pc = m_pc + 1; m_state = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".instr"}, IfIdInstruct, m_instr);
        check({tag, ".ifidpc"}, IfIdPc, m_ipc);
        check({tag, ".valid"}, {15'd0, IfIdValid}, {15'd0, m_valid});
        check({tag, ".state"}, {14'd0, FetchState}, 16'(m_state));
`ifdef FETCH_STALL_COUNTER_EN
        check({tag, ".stall"}, StallCount, m_sc);
`endif
    endtask

    task automatic drive(input logic r, input logic ns, input logic br, input logic [15:0] tgt,
                         input logic mc, input logic hz, input logic [15:0] ins);
        rst = r; noStop = ns; BranchTaken = br; BranchTarget = tgt;
        MemConflict = mc; HazardStall = hz; Instruct = ins;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset for two cycles
        drive(1, 1, 0, 0, 0, 0, 16'h0000);
        cycle("rst0");
        cycle("rst1");
        check("rst.pc_lit", pc, 16'h0000);
        check("rst.instr_lit", IfIdInstruct, 16'h0800);
        drive(0, 1, 0, 0, 0, 0, 16'h1234);
        cycle("first");
        check("first.instr_lit", IfIdInstruct, 16'h1234);
        check("first.ifidpc_lit", IfIdPc, 16'h0001);

        // Conflict replay at 0x0010
        drive(0, 1, 1, 16'h0010, 0, 0, 16'h0000);
        cycle("br10");
        drive(0, 1, 0, 0, 1, 0, 16'hDEAD);
        cycle("mc0");
        cycle("mc1");
        check("mc.pc_lit", pc, 16'h0010);
        check("mc.state_lit", {14'd0, FetchState}, 16'd1);
        drive(0, 1, 0, 0, 0, 0, 16'hABCD);
        cycle("mcclr");
        check("mcclr.instr_lit", IfIdInstruct, 16'hABCD);
        check("mcclr.ifidpc_lit", IfIdPc, 16'h0011);

        // UART freeze at 0x0020 (branch held asserted, must be ignored)
        drive(0, 1, 1, 16'h0020, 0, 0, 16'h0000);
        cycle("br20");
        drive(0, 1, 0, 0, 0, 0, 16'h5555);
        cycle("f20");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 16'h0300, (i == 2), (i == 3), 16'h7777);
            cycle("frz");
        end
        check("frz.pc_lit", pc, 16'h0021);
        check("frz.state_lit", {14'd0, FetchState}, 16'd2);
        drive(0, 1, 0, 0, 0, 0, 16'h6666);
        cycle("unfrz");

        // Branch beats conflict
        drive(0, 1, 1, 16'h0100, 1, 0, 16'h0000);
        cycle("brmc");
        check("brmc.pc_lit", pc, 16'h0100);

        // PC wrap
        drive(0, 1, 1, 16'hFFFF, 0, 0, 16'h0000);
        cycle("brff");
        drive(0, 1, 0, 0, 0, 0, 16'h4000);
        cycle("wrap");
        check("wrap.pc_lit", pc, 16'h0000);
        check("wrap.ifidpc_lit", IfIdPc, 16'h0000);

        // Hazard stall at 0x0030
        drive(0, 1, 1, 16'h0030, 0, 0, 16'h0000);
        cycle("br30");
        drive(0, 1, 0, 0, 0, 1, 16'h9999);
        cycle("hz");
        check("hz.pc_lit", pc, 16'h0030);
        drive(0, 1, 0, 0, 0, 0, 16'h8888);
        cycle("hzres");
        check("hzres.pc_lit", pc, 16'h0031);

        // Reset mid-replay and mid-freeze
        drive(0, 1, 0, 0, 1, 0, 16'h0000);
        cycle("prerst");
        drive(1, 1, 0, 0, 1, 0, 16'h0000);
        cycle("rstrep");
        drive(0, 0, 0, 0, 0, 0, 16'h0000);
        cycle("prerst2");
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        cycle("rstfrz");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 16'($urandom));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
